// File: rtl/isa_stream_tx.sv
// isa_stream_tx: fetches ISA words from SRAM, frames/filters instructions, streams them (clk, rst_n async low; start/base_addr/num_instr in; busy/done/err out; mem_rd_* SRAM port; tx_* valid/ready stream)
module isa_stream_tx #(
  parameter int PORT_WIDTH    = 128,
  parameter int ADDR_WIDTH    = 16,
  parameter int OPCODE_WIDTH  = 8,
  parameter int NUMWORD_WIDTH = 8,
  parameter int OPNUM         = 6,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [15:0]           num_instr,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [PORT_WIDTH-1:0] mem_rd_dat,
  output logic [PORT_WIDTH-1:0] tx_dat,
  output logic                  tx_vld,
  output logic                  tx_last,
  input  logic                  tx_rdy
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [31:0] OPN = 32'(OPNUM);
  typedef enum logic [2:0] {IDLE, HDR, HWAIT, BODY, DRAIN} state_t;
  state_t state, state_nx;
  logic [ADDR_WIDTH-1:0] addr;
  logic [15:0] cnt;
  logic [NUMWORD_WIDTH-1:0] rem, n_raw, n;
  logic [OPCODE_WIDTH-1:0] opc;
  logic inflight, rd_last, drop, zero_done;
  logic opc_ok, slot_free, rd_en, push, push_last, pop, body_end, drained;
  logic [PORT_WIDTH:0] fifo [FIFO_DEPTH];
  logic [PORT_WIDTH:0] head;
  logic [PW-1:0] wp, rp;
  logic [CW-1:0] count;
  assign opc       = mem_rd_dat[OPCODE_WIDTH-1:0];
  assign n_raw     = mem_rd_dat[OPCODE_WIDTH +: NUMWORD_WIDTH];
  assign n         = (n_raw == '0) ? NUMWORD_WIDTH'(1) : n_raw;
  assign opc_ok    = 32'(opc) < OPN;
  // A read reserves a buffer slot until its data lands, even if it is later dropped
  assign slot_free = (count + CW'(inflight)) < CW'(FIFO_DEPTH);
  assign rd_en     = slot_free && (state == HDR || (state == BODY && rem != '0));
  // HWAIT always has the header read in flight; BODY returns carry rd_last
  assign push      = inflight && ((state == HWAIT) ? opc_ok : (state == BODY && !drop));
  assign push_last = (state == HWAIT) ? (n == NUMWORD_WIDTH'(1)) : rd_last;
  assign body_end  = state == BODY && inflight && rd_last;
  assign drained   = count == '0 && !inflight;
  assign tx_vld    = count != '0;
  assign pop       = tx_vld && tx_rdy;
  assign head      = fifo[rp];
  assign tx_dat    = tx_vld ? head[PORT_WIDTH-1:0] : '0;
  assign tx_last   = tx_vld && head[PORT_WIDTH];
  assign mem_rd_en   = rd_en;
  assign mem_rd_addr = addr;
  assign busy      = state != IDLE;
  assign done      = (state == DRAIN && drained) || zero_done;
  always_comb begin
    state_nx = state;
    state_nx = (state == IDLE)  ? ((start && num_instr != '0) ? HDR : IDLE) :
               (state == HDR)   ? (rd_en ? HWAIT : HDR) :
               (state == HWAIT) ? ((n != NUMWORD_WIDTH'(1)) ? BODY : (cnt != 16'd1) ? HDR : DRAIN) :
               (state == BODY)  ? (body_end ? ((cnt != '0) ? HDR : DRAIN) : BODY) :
               (drained ? IDLE : DRAIN);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      addr      <= '0;
      cnt       <= '0;
      rem       <= '0;
      inflight  <= 1'b0;
      rd_last   <= 1'b0;
      drop      <= 1'b0;
      err       <= 1'b0;
      zero_done <= 1'b0;
      wp        <= '0;
      rp        <= '0;
      count     <= '0;
    end else begin
      state     <= state_nx;
      inflight  <= rd_en;
      rd_last   <= state == BODY && rem == NUMWORD_WIDTH'(1);
      zero_done <= state == IDLE && start && num_instr == '0;
      if (state == IDLE && start) begin
        addr <= base_addr;
        cnt  <= num_instr;
        err  <= 1'b0;
      end else if (rd_en) addr <= addr + ADDR_WIDTH'(1);
      if (state == HWAIT) begin
        cnt  <= cnt - 16'd1;
        rem  <= n - NUMWORD_WIDTH'(1);
        drop <= !opc_ok;
        if (!opc_ok) err <= 1'b1;
      end else if (state == BODY && rd_en) rem <= rem - NUMWORD_WIDTH'(1);
      if (push) wp <= wp + PW'(1);
      if (pop) rp <= rp + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end
  always_ff @(posedge clk) if (push) fifo[wp] <= {push_last, mem_rd_dat};
endmodule

// File: tb/tb_isa_stream_tx.sv
// tb_isa_stream_tx: randomized and directed self-checking bench for isa_stream_tx against a program-level reference model
module tb_isa_stream_tx;
  logic clk = 0, rst_n = 0, start = 0, busy, done, err, mem_rd_en, tx_vld, tx_last, tx_rdy = 0;
  logic [15:0] base_addr = 0, num_instr = 0, mem_rd_addr;
  logic [127:0] mem_rd_dat = 0, tx_dat;
  logic [127:0] sram [65536];
  logic [128:0] tx_q[$], exp_tx[$];
  logic [15:0] rd_q[$], exp_rd[$];
  int tx_t[$];
  int n_chk = 0, n_fail = 0, cyc = 0, t0 = 0, done_n = 0, done_t = 0, rdy_pct = 100, held_rd = 0;
  bit rdy_hold = 0, exp_err = 0, prev_stall = 0;
  logic [129:0] prev_word = 0;
  isa_stream_tx dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .num_instr(num_instr),
    .busy(busy), .done(done), .err(err), .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
    .mem_rd_dat(mem_rd_dat), .tx_dat(tx_dat), .tx_vld(tx_vld), .tx_last(tx_last), .tx_rdy(tx_rdy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) mem_rd_dat <= mem_rd_en ? sram[mem_rd_addr] : {$urandom, $urandom, $urandom, $urandom};
  initial forever begin
    @(posedge clk);
    #1 tx_rdy = !rdy_hold && ($urandom_range(99) < rdy_pct);
  end
  task automatic chk(input string tag, input logic [129:0] got, input logic [129:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (rst_n && prev_stall) chk("hold_stable", {tx_vld, tx_last, tx_dat}, prev_word);
    prev_stall = rst_n && tx_vld && !tx_rdy;
    prev_word = {tx_vld, tx_last, tx_dat};
    if (mem_rd_en) rd_q.push_back(mem_rd_addr);
    if (tx_vld && tx_rdy) begin
      tx_q.push_back({tx_last, tx_dat});
      tx_t.push_back(cyc - t0);
    end
    if (done) begin
      done_n++;
      done_t = cyc - t0;
    end
  end
  function automatic logic [127:0] rnd();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction
  task automatic put(inout logic [15:0] a, input int opc, input int nf);
    logic [127:0] w;
    int n;
    w = rnd();
    w[15:0] = {8'(nf), 8'(opc)};
    sram[a] = w;
    a++;
    n = (nf == 0) ? 1 : nf;
    for (int j = 1; j < n; j++) begin
      sram[a] = rnd();
      a++;
    end
  endtask
  task automatic model(input logic [15:0] base, input int num);
    logic [15:0] a;
    logic [127:0] h;
    int n;
    bit ok;
    a = base;
    exp_tx.delete();
    exp_rd.delete();
    exp_err = 0;
    for (int i = 0; i < num; i++) begin
      h = sram[a];
      exp_rd.push_back(a);
      n = (h[15:8] == 0) ? 1 : int'(h[15:8]);
      ok = h[7:0] < 6;
      if (!ok) exp_err = 1;
      if (ok) exp_tx.push_back({n == 1, h});
      a++;
      for (int j = 1; j < n; j++) begin
        exp_rd.push_back(a);
        if (ok) exp_tx.push_back({j == n - 1, sram[a]});
        a++;
      end
    end
  endtask
  task automatic run(input logic [15:0] base, input int num, input int pct, input int hold, input bit restart);
    model(base, num);
    rdy_pct = pct;
    rdy_hold = hold > 0;
    tx_q.delete();
    rd_q.delete();
    tx_t.delete();
    done_n = 0;
    @(posedge clk);
    #1 start = 1;
    base_addr = base;
    num_instr = 16'(num);
    t0 = cyc;
    for (int c = 1; c < 3000 && done_n == 0; c++) begin
      @(posedge clk);
      #1 start = restart && c == 2;
      if (start) begin
        base_addr = 16'h5555;
        num_instr = 16'd7;
      end
      if (c == hold) begin
        held_rd = rd_q.size();
        rdy_hold = 0;
      end
    end
    repeat (3) @(posedge clk);
    #1;
    chk("done_count", 130'(done_n), 130'(1));
    chk("busy_after", 130'(busy), 130'(0));
    chk("err_flag", 130'(err), 130'(exp_err));
    chk("rd_count", 130'(rd_q.size()), 130'(exp_rd.size()));
    for (int i = 0; i < exp_rd.size() && i < rd_q.size(); i++) chk("rd_addr", 130'(rd_q[i]), 130'(exp_rd[i]));
    chk("tx_count", 130'(tx_q.size()), 130'(exp_tx.size()));
    for (int i = 0; i < exp_tx.size() && i < tx_q.size(); i++) chk("tx_word", 130'(tx_q[i]), 130'(exp_tx[i]));
  endtask
  initial begin
    logic [15:0] a, b;
    int num;
    repeat (3) @(posedge clk);
    #1 chk("reset_outputs", 130'({busy, done, err, mem_rd_en, tx_vld, tx_last, tx_dat}), 130'(0));
    @(negedge clk) rst_n = 1;
    a = 16'h0010;
    put(a, 2, 3);
    run(16'h0010, 1, 100, 0, 0);
    chk("t1_tx_n", 130'(tx_t.size()), 130'(3));
    if (tx_t.size() == 3) chk("t1_tx_cycles", 130'({tx_t[0][7:0], tx_t[1][7:0], tx_t[2][7:0]}), 130'(24'h030506));
    chk("t1_done_cycle", 130'(done_t), 130'(7));
    a = 16'h0100;
    put(a, 0, 1);
    put(a, 5, 2);
    run(16'h0100, 2, 100, 10, 0);
    chk("t2_reads_held", 130'(held_rd), 130'(3));
    a = 16'h0180;
    put(a, 4, 7);
    run(16'h0180, 1, 100, 20, 0);
    chk("credit_reads_held", 130'(held_rd), 130'(4));
    a = 16'h0200;
    put(a, 9, 4);
    put(a, 1, 1);
    run(16'h0200, 2, 70, 0, 0);
    chk("drop_err_held", 130'(err), 130'(1));
    a = 16'h0300;
    put(a, 3, 0);
    put(a, 1, 1);
    run(16'h0300, 2, 100, 0, 0);
    chk("nw0_err_cleared", 130'(err), 130'(0));
    run(16'h0400, 0, 100, 0, 0);
    chk("zero_done_cycle", 130'(done_t), 130'(1));
    a = 16'h0500;
    put(a, 1, 3);
    put(a, 2, 2);
    run(16'h0500, 2, 60, 0, 1);
    a = 16'hFFFF;
    put(a, 1, 2);
    run(16'hFFFF, 1, 100, 0, 0);
    chk("wrap_second_addr", 130'(rd_q.size() == 2 ? rd_q[1] : 16'h1234), 130'(0));
    a = 16'h0600;
    put(a, 1, 8);
    done_n = 0;
    rdy_pct = 100;
    @(posedge clk);
    #1 start = 1;
    base_addr = 16'h0600;
    num_instr = 16'd1;
    @(posedge clk);
    #1 start = 0;
    repeat (4) @(posedge clk);
    @(negedge clk) rst_n = 0;
    #1 chk("rst_mid_body", 130'({tx_vld, busy}), 130'(0));
    repeat (3) @(posedge clk);
    #1 chk("rst_no_done", 130'(done_n), 130'(0));
    @(negedge clk) rst_n = 1;
    for (int k = 0; k < 8; k++) begin
      b = 16'($urandom);
      a = b;
      num = $urandom_range(1, 5);
      for (int i = 0; i < num; i++) put(a, $urandom_range(0, 8), $urandom_range(0, 5));
      run(b, num, $urandom_range(30, 100), 0, 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
